// File: rtl/adc_uart_pkg.sv
// ============================================================================
//  Module      : adc_uart_pkg
//  Description : Shared types and constants for the ADC-to-UART packetizer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package adc_uart_pkg;

    localparam int          FRAME_LEN     = 5;
    localparam int          SEQ_W         = 6;
    localparam int          CHAN_W_FIXED  = 2;
    localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SYNC = 3'd1,
        ST_HDR  = 3'd2,
        ST_DHI  = 3'd3,
        ST_DLO  = 3'd4,
        ST_CSUM = 3'd5
    } state_t;

    typedef struct packed {
        logic [CHAN_W_FIXED-1:0] chan;
        logic [SEQ_W-1:0]        seq;
        logic [15:0]             data16;
    } frame_t;

    function automatic logic [7:0] frame_csum(input frame_t f);
        return {f.chan, f.seq} ^ f.data16[15:8] ^ f.data16[7:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/adc_uart_packetizer.sv
// ============================================================================
//  Module      : adc_uart_packetizer
//  Description : Frames ADC samples into 5-byte packets on a valid/ready byte
//                stream, with a one-deep pending slot and a drop counter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adc_uart_packetizer
    import adc_uart_pkg::*;
#(
    parameter int         SAMPLE_W  = 12,
    parameter int         CHAN_W    = 2,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic                smp_stb,
    input  logic [SAMPLE_W-1:0] smp_data,
    input  logic [CHAN_W-1:0]   smp_chan,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic [7:0]          tx_data,
    output logic                busy,
    output logic [7:0]          drop_cnt
);

    state_t           r_state;
    state_t           w_state_nxt;
    frame_t           r_frame;
    frame_t           r_slot;
    logic             r_slot_full;
    logic [SEQ_W-1:0] r_seq;
    logic [7:0]       r_drop_cnt;
    logic             r_tx_valid;
    logic [7:0]       r_tx_data;

    logic             w_fire;
    logic             w_take;
    logic             w_accept;
    logic             w_drop;
    logic [15:0]      w_data16;
    logic [7:0]       w_byte_nxt;

    always_comb begin
        w_data16               = '0;
        w_data16[SAMPLE_W-1:0] = smp_data;
    end

    assign w_fire = r_tx_valid & tx_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (r_slot_full) begin
                    w_state_nxt = ST_SYNC;
                    w_take      = 1'b1;
                end
            end
            ST_SYNC: if (w_fire) w_state_nxt = ST_HDR;
            ST_HDR:  if (w_fire) w_state_nxt = ST_DHI;
            ST_DHI:  if (w_fire) w_state_nxt = ST_DLO;
            ST_DLO:  if (w_fire) w_state_nxt = ST_CSUM;
            ST_CSUM: begin
                if (w_fire) begin
                    // Chain straight into the pending frame to avoid an idle bubble
                    if (r_slot_full) begin
                        w_state_nxt = ST_SYNC;
                        w_take      = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // The byte for the upcoming state; SYNC needs no frame content, so loading
    // the frame register on the same edge is safe.
    always_comb begin
        w_byte_nxt = 8'h00;
        unique case (w_state_nxt)
            ST_SYNC: w_byte_nxt = SYNC_BYTE;
            ST_HDR:  w_byte_nxt = {r_frame.chan, r_frame.seq};
            ST_DHI:  w_byte_nxt = r_frame.data16[15:8];
            ST_DLO:  w_byte_nxt = r_frame.data16[7:0];
            ST_CSUM: w_byte_nxt = frame_csum(r_frame);
            default: w_byte_nxt = 8'h00;
        endcase
    end

    assign w_accept = smp_stb & (~r_slot_full | w_take);
    assign w_drop   = smp_stb & r_slot_full & ~w_take;

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            r_state     <= ST_IDLE;
            r_frame     <= '0;
            r_slot      <= '0;
            r_slot_full <= 1'b0;
            r_seq       <= '0;
            r_drop_cnt  <= 8'h00;
            r_tx_valid  <= 1'b0;
            r_tx_data   <= 8'h00;
        end else begin
            r_state    <= w_state_nxt;
            r_tx_valid <= (w_state_nxt != ST_IDLE);
            r_tx_data  <= w_byte_nxt;
            if (w_take) begin
                r_frame <= r_slot;
            end
            if (w_accept) begin
                r_slot      <= '{chan: smp_chan, seq: r_seq, data16: w_data16};
                r_slot_full <= 1'b1;
            end else if (w_take) begin
                r_slot_full <= 1'b0;
            end
            if (smp_stb) begin
                r_seq <= r_seq + 1'b1;
            end
            if (w_drop && (r_drop_cnt != 8'hFF)) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end
    end

    assign tx_valid = r_tx_valid;
    assign tx_data  = r_tx_data;
    assign busy     = (r_state != ST_IDLE) | r_slot_full;
    assign drop_cnt = r_drop_cnt;

endmodule

`default_nettype wire
